// File: rtl/fpu_wb_csr.sv
// Writeback router and FP CSR block wrapped around the fixed-latency half-precision FPU.
// Resolves dynamic rounding, tracks ops to retirement and owns fflags/frm/fcsr.
module fpu_wb_csr #(
  parameter int unsigned STD  = 15,
  parameter int unsigned LAT  = 2,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_l,
  // Issue side
  input  logic            issue_valid,
  input  logic [RD_W-1:0] issue_rd,
  input  logic            issue_is_fp,
  input  logic [2:0]      issue_rm,
  output logic [2:0]      frm_w,
  output logic            rm_illegal,
  // FPU results
  input  logic [STD:0]    fpu_result,
  input  logic [31:0]     fpu_result_rd,
  input  logic [4:0]      fpu_flags,
  // Register-file write ports
  output logic            fp_wb_valid,
  output logic [RD_W-1:0] fp_wb_addr,
  output logic [STD:0]    fp_wb_data,
  output logic            int_wb_valid,
  output logic [RD_W-1:0] int_wb_addr,
  output logic [31:0]     int_wb_data,
  // CSR access
  input  logic            csr_valid,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [31:0]     csr_wdata,
  output logic            csr_ready,
  output logic [31:0]     csr_rdata,
  output logic            csr_illegal,
  output logic [4:0]      fflags,
  output logic [2:0]      frm,
  output logic            busy
);

  localparam logic [11:0] AddrFflags = 12'h001;
  localparam logic [11:0] AddrFrm    = 12'h002;
  localparam logic [11:0] AddrFcsr   = 12'h003;

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpSet   = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  logic [LAT-1:0]  pipe_valid_q;
  logic [LAT-1:0]  pipe_fp_q;
  logic [RD_W-1:0] pipe_rd_q [LAT];

  logic            ret_valid;
  logic            ret_fp;
  logic [RD_W-1:0] ret_rd;

  logic            fp_wb_valid_q, int_wb_valid_q;
  logic [RD_W-1:0] fp_wb_addr_q, int_wb_addr_q;
  logic [STD:0]    fp_wb_data_q;
  logic [31:0]     int_wb_data_q;

  logic [4:0] fflags_q, fflags_d;
  logic [2:0] frm_q, frm_d;

  logic [2:0] rm_res;
  logic       rm_bad;

  logic       addr_fflags, addr_frm, addr_fcsr, addr_legal;
  logic       csr_fire;
  logic [7:0] csr_old, csr_new;
  logic       unused_wdata;

  // Rounding-mode resolution: 3'b111 selects the architectural frm.
  assign rm_res     = (issue_rm == 3'b111) ? frm_q : issue_rm;
  assign rm_bad     = rm_res[2] & (rm_res[1] | rm_res[0]);
  assign frm_w      = rm_res;
  assign rm_illegal = issue_valid & rm_bad;

  // Tracking pipe; the last stage lines up with the FPU output register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pipe_valid_q <= '0;
      pipe_fp_q    <= '0;
      for (int i = 0; i < LAT; i++) begin
        pipe_rd_q[i] <= '0;
      end
    end else begin
      pipe_valid_q[0] <= issue_valid & ~rm_bad;
      pipe_fp_q[0]    <= issue_is_fp;
      pipe_rd_q[0]    <= issue_rd;
      for (int i = 1; i < LAT; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_fp_q[i]    <= pipe_fp_q[i-1];
        pipe_rd_q[i]    <= pipe_rd_q[i-1];
      end
    end
  end

  assign ret_valid = pipe_valid_q[LAT-1];
  assign ret_fp    = pipe_fp_q[LAT-1];
  assign ret_rd    = pipe_rd_q[LAT-1];
  assign busy      = |pipe_valid_q;

  // Writeback registers; addr/data only move when their port retires an op.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      fp_wb_valid_q  <= 1'b0;
      fp_wb_addr_q   <= '0;
      fp_wb_data_q   <= '0;
      int_wb_valid_q <= 1'b0;
      int_wb_addr_q  <= '0;
      int_wb_data_q  <= '0;
    end else begin
      fp_wb_valid_q  <= ret_valid & ret_fp;
      int_wb_valid_q <= ret_valid & ~ret_fp & (ret_rd != '0);
      if (ret_valid & ret_fp) begin
        fp_wb_addr_q <= ret_rd;
        fp_wb_data_q <= fpu_result;
      end
      if (ret_valid & ~ret_fp) begin
        int_wb_addr_q <= ret_rd;
        int_wb_data_q <= fpu_result_rd;
      end
    end
  end

  assign fp_wb_valid  = fp_wb_valid_q;
  assign fp_wb_addr   = fp_wb_addr_q;
  assign fp_wb_data   = fp_wb_data_q;
  assign int_wb_valid = int_wb_valid_q;
  assign int_wb_addr  = int_wb_addr_q;
  assign int_wb_data  = int_wb_data_q;

  // CSR decode. Flag-touching addresses wait until nothing is in flight so a
  // retiring op can never race an fflags update.
  assign addr_fflags = (csr_addr == AddrFflags);
  assign addr_frm    = (csr_addr == AddrFrm);
  assign addr_fcsr   = (csr_addr == AddrFcsr);
  assign addr_legal  = addr_fflags | addr_frm | addr_fcsr;
  assign csr_ready   = ~(busy & (addr_fflags | addr_fcsr));
  assign csr_fire    = csr_valid & csr_ready & addr_legal;
  assign csr_illegal = csr_valid & ~addr_legal;

  always_comb begin
    csr_old = '0;
    if (addr_fflags) begin
      csr_old = {3'b000, fflags_q};
    end else if (addr_frm) begin
      csr_old = {5'b00000, frm_q};
    end else if (addr_fcsr) begin
      csr_old = {frm_q, fflags_q};
    end
  end

  // Only the low byte can land in any field, so the update works on 8 bits.
  always_comb begin
    csr_new = csr_old;
    unique case (csr_op)
      OpRead:  csr_new = csr_old;
      OpWrite: csr_new = csr_wdata[7:0];
      OpSet:   csr_new = csr_old | csr_wdata[7:0];
      OpClear: csr_new = csr_old & ~csr_wdata[7:0];
      default: csr_new = csr_old;
    endcase
  end

  assign unused_wdata = ^csr_wdata[31:8];
  assign csr_rdata    = {24'b0, csr_old};

  always_comb begin
    fflags_d = fflags_q;
    frm_d    = frm_q;
    if (ret_valid) begin
      fflags_d = fflags_q | fpu_flags;
    end
    if (csr_fire) begin
      if (addr_fflags) begin
        fflags_d = csr_new[4:0];
      end
      if (addr_frm) begin
        frm_d = csr_new[2:0];
      end
      if (addr_fcsr) begin
        frm_d    = csr_new[7:5];
        fflags_d = csr_new[4:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      fflags_q <= '0;
      frm_q    <= '0;
    end else begin
      fflags_q <= fflags_d;
      frm_q    <= frm_d;
    end
  end

  assign fflags = fflags_q;
  assign frm    = frm_q;

endmodule

// File: tb/tb_fpu_wb_csr.sv
// Self-checking bench for fpu_wb_csr: directed tables, corner sequences and a
// randomized run compared against a queue-based retirement model.
module tb_fpu_wb_csr;
  localparam int unsigned STD  = 15;
  localparam int unsigned LAT  = 2;
  localparam int unsigned RD_W = 5;

  logic            clk = 1'b0;
  logic            rst_l = 1'b0;
  logic            issue_valid;
  logic [RD_W-1:0] issue_rd;
  logic            issue_is_fp;
  logic [2:0]      issue_rm;
  logic [2:0]      frm_w;
  logic            rm_illegal;
  logic [STD:0]    fpu_result;
  logic [31:0]     fpu_result_rd;
  logic [4:0]      fpu_flags;
  logic            fp_wb_valid;
  logic [RD_W-1:0] fp_wb_addr;
  logic [STD:0]    fp_wb_data;
  logic            int_wb_valid;
  logic [RD_W-1:0] int_wb_addr;
  logic [31:0]     int_wb_data;
  logic            csr_valid;
  logic [1:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [31:0]     csr_wdata;
  logic            csr_ready;
  logic [31:0]     csr_rdata;
  logic            csr_illegal;
  logic [4:0]      fflags;
  logic [2:0]      frm;
  logic            busy;

  always #5 clk = ~clk;

  fpu_wb_csr #(.STD(STD), .LAT(LAT), .RD_W(RD_W)) dut (
    .clk(clk), .rst_l(rst_l),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_fp(issue_is_fp),
    .issue_rm(issue_rm), .frm_w(frm_w), .rm_illegal(rm_illegal),
    .fpu_result(fpu_result), .fpu_result_rd(fpu_result_rd), .fpu_flags(fpu_flags),
    .fp_wb_valid(fp_wb_valid), .fp_wb_addr(fp_wb_addr), .fp_wb_data(fp_wb_data),
    .int_wb_valid(int_wb_valid), .int_wb_addr(int_wb_addr), .int_wb_data(int_wb_data),
    .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_ready(csr_ready), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .fflags(fflags), .frm(frm), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural CSRs plus a queue of ops keyed by retire edge.
  typedef struct {
    int unsigned     ret;
    logic [RD_W-1:0] rd;
    logic            is_fp;
  } op_t;

  op_t             pend[$];
  int unsigned     edge_cnt = 0;
  logic [2:0]      m_frm = '0;
  logic [4:0]      m_fflags = '0;
  logic            m_fp_v = 1'b0, m_int_v = 1'b0;
  logic [RD_W-1:0] m_fp_a = '0, m_int_a = '0;
  logic [STD:0]    m_fp_d = '0;
  logic [31:0]     m_int_d = '0;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ill;
    logic [2:0]  frm;
    logic [4:0]  ff;
  } csr_vec_t;

  typedef struct {
    logic [2:0] rm;
    logic       valid;
    logic [2:0] frm_w;
    logic       ill;
  } rm_vec_t;

  csr_vec_t cvec[11];
  rm_vec_t  rvec[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    issue_rd    = '0;
    issue_is_fp = 1'b0;
    issue_rm    = 3'b000;
    csr_valid   = 1'b0;
    csr_op      = 2'b00;
    csr_addr    = 12'h000;
    csr_wdata   = '0;
  endtask

  task automatic issue(input logic [RD_W-1:0] rd, input logic fp, input logic [2:0] rm);
    issue_valid = 1'b1;
    issue_rd    = rd;
    issue_is_fp = fp;
    issue_rm    = rm;
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    csr_valid = 1'b1;
    csr_op    = op;
    csr_addr  = addr;
    csr_wdata = wd;
  endtask

  task automatic model_reset();
    pend.delete();
    m_frm    = '0;
    m_fflags = '0;
    m_fp_v   = 1'b0;
    m_int_v  = 1'b0;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic step();
    logic [2:0]      e_frm_w;
    logic            e_bad, e_ready, e_legal;
    logic [7:0]      old, nv;
    logic            c_iv, c_fp, c_cv;
    logic [RD_W-1:0] c_rd;
    logic [1:0]      c_op;
    logic [11:0]     c_addr;
    logic [31:0]     c_wd;
    logic [STD:0]    r_fp;
    logic [31:0]     r_int;
    logic [4:0]      r_fl;
    op_t             op;
    #1;
    e_frm_w = (issue_rm == 3'b111) ? m_frm : issue_rm;
    e_bad   = (e_frm_w >= 3'd5);
    e_legal = (csr_addr == 12'h001) || (csr_addr == 12'h002) || (csr_addr == 12'h003);
    e_ready = !((pend.size() != 0) && ((csr_addr == 12'h001) || (csr_addr == 12'h003)));
    case (csr_addr)
      12'h001: old = {3'b000, m_fflags};
      12'h002: old = {5'b00000, m_frm};
      12'h003: old = {m_frm, m_fflags};
      default: old = 8'h00;
    endcase
    chk("frm_w", {29'b0, frm_w}, {29'b0, e_frm_w});
    chk("rm_illegal", {31'b0, rm_illegal}, {31'b0, issue_valid & e_bad});
    chk("csr_ready", {31'b0, csr_ready}, {31'b0, e_ready});
    if (csr_valid && e_ready) begin
      chk("csr_rdata", csr_rdata, {24'b0, old});
      chk("csr_illegal", {31'b0, csr_illegal}, {31'b0, !e_legal});
    end
    c_iv = issue_valid; c_rd = issue_rd; c_fp = issue_is_fp;
    c_cv = csr_valid; c_op = csr_op; c_addr = csr_addr; c_wd = csr_wdata;
    r_fp = fpu_result; r_int = fpu_result_rd; r_fl = fpu_flags;
    @(posedge clk);
    edge_cnt++;
    m_fp_v  = 1'b0;
    m_int_v = 1'b0;
    if (pend.size() != 0 && pend[0].ret == edge_cnt) begin
      op = pend.pop_front();
      m_fflags = m_fflags | r_fl;
      if (op.is_fp) begin
        m_fp_v = 1'b1; m_fp_a = op.rd; m_fp_d = r_fp;
      end else begin
        m_int_v = (op.rd != '0); m_int_a = op.rd; m_int_d = r_int;
      end
    end
    if (c_iv && !e_bad) pend.push_back('{ret: edge_cnt + LAT, rd: c_rd, is_fp: c_fp});
    if (c_cv && e_ready && e_legal) begin
      case (c_op)
        2'b01:   nv = c_wd[7:0];
        2'b10:   nv = old | c_wd[7:0];
        2'b11:   nv = old & ~c_wd[7:0];
        default: nv = old;
      endcase
      if (c_addr == 12'h001) m_fflags = nv[4:0];
      if (c_addr == 12'h002) m_frm = nv[2:0];
      if (c_addr == 12'h003) begin
        m_frm    = nv[7:5];
        m_fflags = nv[4:0];
      end
    end
    #1;
    chk("fp_wb_valid", {31'b0, fp_wb_valid}, {31'b0, m_fp_v});
    chk("int_wb_valid", {31'b0, int_wb_valid}, {31'b0, m_int_v});
    if (m_fp_v) begin
      chk("fp_wb_addr", {27'b0, fp_wb_addr}, {27'b0, m_fp_a});
      chk("fp_wb_data", {16'b0, fp_wb_data}, {16'b0, m_fp_d});
    end
    if (m_int_v) begin
      chk("int_wb_addr", {27'b0, int_wb_addr}, {27'b0, m_int_a});
      chk("int_wb_data", int_wb_data, m_int_d);
    end
    chk("fflags", {27'b0, fflags}, {27'b0, m_fflags});
    chk("frm", {29'b0, frm}, {29'b0, m_frm});
    chk("busy", {31'b0, busy}, {31'b0, pend.size() != 0});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall;
    cvec[0]  = '{2'b01, 12'h002, 32'h0000_0002, 32'h00, 1'b0, 3'd2, 5'h00};
    cvec[1]  = '{2'b10, 12'h001, 32'h0000_0011, 32'h00, 1'b0, 3'd2, 5'h11};
    cvec[2]  = '{2'b11, 12'h001, 32'h0000_0001, 32'h11, 1'b0, 3'd2, 5'h10};
    cvec[3]  = '{2'b00, 12'h003, 32'h0000_0000, 32'h50, 1'b0, 3'd2, 5'h10};
    cvec[4]  = '{2'b01, 12'h003, 32'hFFFF_FFE5, 32'h50, 1'b0, 3'd7, 5'h05};
    cvec[5]  = '{2'b00, 12'h003, 32'h0000_0000, 32'hE5, 1'b0, 3'd7, 5'h05};
    cvec[6]  = '{2'b00, 12'h004, 32'h0000_0000, 32'h00, 1'b1, 3'd7, 5'h05};
    cvec[7]  = '{2'b01, 12'h004, 32'h0000_00FF, 32'h00, 1'b1, 3'd7, 5'h05};
    cvec[8]  = '{2'b11, 12'h003, 32'h0000_00FF, 32'hE5, 1'b0, 3'd0, 5'h00};
    cvec[9]  = '{2'b10, 12'h002, 32'hFFFF_FFFD, 32'h00, 1'b0, 3'd5, 5'h00};
    cvec[10] = '{2'b01, 12'h002, 32'h0000_0002, 32'h05, 1'b0, 3'd2, 5'h00};
    // Applied with frm = 3'b010.
    rvec[0] = '{3'b111, 1'b1, 3'b010, 1'b0};
    rvec[1] = '{3'b000, 1'b1, 3'b000, 1'b0};
    rvec[2] = '{3'b100, 1'b1, 3'b100, 1'b0};
    rvec[3] = '{3'b101, 1'b1, 3'b101, 1'b1};
    rvec[4] = '{3'b110, 1'b0, 3'b110, 1'b0};
    rvec[5] = '{3'b111, 1'b0, 3'b010, 1'b0};
    rvec[6] = '{3'b110, 1'b1, 3'b110, 1'b1};

    idle();
    fpu_result = '0; fpu_result_rd = '0; fpu_flags = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fp_wb_valid", {31'b0, fp_wb_valid}, 32'd0);
    chk("rst_int_wb_valid", {31'b0, int_wb_valid}, 32'd0);
    chk("rst_fflags", {27'b0, fflags}, 32'd0);
    chk("rst_frm", {29'b0, frm}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst_l = 1'b1;

    // CSR table
    for (int i = 0; i < 11; i++) begin
      csr(cvec[i].op, cvec[i].addr, cvec[i].wdata);
      #1;
      chk($sformatf("tbl_csr%0d_rdata", i), csr_rdata, cvec[i].rdata);
      chk($sformatf("tbl_csr%0d_ill", i), {31'b0, csr_illegal}, {31'b0, cvec[i].ill});
      step();
      chk($sformatf("tbl_csr%0d_frm", i), {29'b0, frm}, {29'b0, cvec[i].frm});
      chk($sformatf("tbl_csr%0d_ff", i), {27'b0, fflags}, {27'b0, cvec[i].ff});
      idle();
    end

    // Rounding-resolution table
    for (int i = 0; i < 7; i++) begin
      issue(5'd7, 1'b1, rvec[i].rm);
      issue_valid = rvec[i].valid;
      #1;
      chk($sformatf("tbl_rm%0d_frm_w", i), {29'b0, frm_w}, {29'b0, rvec[i].frm_w});
      chk($sformatf("tbl_rm%0d_ill", i), {31'b0, rm_illegal}, {31'b0, rvec[i].ill});
      step();
      idle();
    end
    repeat (LAT + 1) step();

    // Dynamic rm resolving to a reserved value: no writeback ever
    csr(2'b01, 12'h002, 32'h5);
    step();
    idle();
    issue(5'd9, 1'b1, 3'b111);
    #1;
    chk("dyn_rm_illegal", {31'b0, rm_illegal}, 32'd1);
    step();
    idle();
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      chk("dyn_no_fp_wb", {31'b0, fp_wb_valid}, 32'd0);
    end

    // Back-to-back routing
    fpu_result = 16'h3C00; fpu_result_rd = 32'h1; fpu_flags = '0;
    issue(5'd1, 1'b1, 3'b000); step();
    issue(5'd2, 1'b0, 3'b000); step();
    issue(5'd0, 1'b0, 3'b000); step();
    idle();
    chk("b2b_fp_v", {31'b0, fp_wb_valid}, 32'd1);
    chk("b2b_fp_a", {27'b0, fp_wb_addr}, 32'd1);
    chk("b2b_fp_d", {16'b0, fp_wb_data}, 32'h3C00);
    step();
    chk("b2b_int_v", {31'b0, int_wb_valid}, 32'd1);
    chk("b2b_int_a", {27'b0, int_wb_addr}, 32'd2);
    chk("b2b_int_d", int_wb_data, 32'h1);
    chk("b2b_fp_1cyc", {31'b0, fp_wb_valid}, 32'd0);
    step();
    chk("b2b_rd0_no_int", {31'b0, int_wb_valid}, 32'd0);
    step();

    // Flag accumulation
    csr(2'b01, 12'h001, 32'h0); step(); idle();
    issue(5'd3, 1'b1, 3'b000); step();
    issue(5'd4, 1'b0, 3'b000); step();
    idle();
    fpu_flags = 5'b00001; step();
    fpu_flags = 5'b10000; step();
    fpu_flags = 5'b00000;
    chk("acc_fflags", {27'b0, fflags}, 32'h11);
    csr(2'b11, 12'h001, 32'h1F);
    #1;
    chk("acc_clr_rdata", csr_rdata, 32'h11);
    step();
    idle();
    chk("acc_clr_fflags", {27'b0, fflags}, 32'h0);

    // Stall of fcsr access while an op is in flight; frm stays ready
    csr(2'b01, 12'h002, 32'h0); step(); idle();
    issue(5'd6, 1'b1, 3'b000); step();
    idle();
    csr(2'b00, 12'h002, 32'h0);
    #1;
    chk("stall_frm_ready", {31'b0, csr_ready}, 32'd1);
    csr_addr = 12'h003;
    fpu_flags = 5'b00100;
    stall = 0;
    while (1) begin
      #1;
      if (csr_ready === 1'b1 || stall >= 8) break;
      step();
      stall++;
    end
    chk("stall_cycles", stall, LAT);
    chk("stall_rdata", csr_rdata, 32'h04);
    step();
    idle();
    fpu_flags = '0;

    // Reset with an op in flight
    csr(2'b01, 12'h002, 32'h3); step(); idle();
    fpu_flags = 5'h1F;
    issue(5'd3, 1'b1, 3'b000); step();
    idle();
    #2;
    rst_l = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rstmid_no_fp_wb", {31'b0, fp_wb_valid}, 32'd0);
      chk("rstmid_busy", {31'b0, busy}, 32'd0);
    end
    chk("rstmid_fflags", {27'b0, fflags}, 32'd0);
    chk("rstmid_frm", {29'b0, frm}, 32'd0);
    rst_l = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      chk("rstmid_after_no_fp_wb", {31'b0, fp_wb_valid}, 32'd0);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      idle();
      fpu_result    = 16'($urandom);
      fpu_result_rd = $urandom;
      fpu_flags     = 5'($urandom);
      if ($urandom_range(1, 0) == 1) issue(5'($urandom), 1'($urandom), 3'($urandom));
      if ($urandom_range(3, 0) == 0) begin
        case ($urandom_range(4, 0))
          0: csr(2'($urandom), 12'h001, $urandom);
          1: csr(2'($urandom), 12'h002, $urandom);
          2: csr(2'($urandom), 12'h003, $urandom);
          3: csr(2'($urandom), 12'h004, $urandom);
          default: csr(2'($urandom), 12'($urandom), $urandom);
        endcase
      end
      step();
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_wb_csr.md
Name: fpu_wb_csr

Overview:
- Wraps the half-precision FPU on both sides.
- Upstream: resolves the instruction rounding mode against the architectural frm register and drives the FPU frm_w input.
- Downstream: tracks each issued op through the fixed FPU latency, then routes the result to the FP or integer register-file write port.
- Owns the fflags/frm/fcsr CSRs. Accumulates retiring exception flags into fflags and serialises CSR accesses against ops still in flight.

Parameters:
- STD, 15, MSB index of FP data (FP data width = STD+1).
- LAT, 2, cycles from issue edge to FPU result validity (input register plus output register).
- RD_W, 5, register index width.

Ports:
- clk  in  1  clock
- rst_l  in  1  asynchronous active-low reset
- issue_valid  in  1  op issued to FPU this cycle; FPU samples it at the same edge
- issue_rd  in  RD_W  destination register index
- issue_is_fp  in  1  1 = FP destination, 0 = integer destination (compare/class/cvt.w/fmv.x)
- issue_rm  in  3  instruction rm field
- frm_w  out  3  resolved rounding mode to FPU
- rm_illegal  out  1  resolved rm is 101/110/111 (combinational)
- fpu_result  in  STD+1  FPU FP result
- fpu_result_rd  in  32  FPU integer result
- fpu_flags  in  5  FPU status flags {NV,DZ,OF,UF,NX}
- fp_wb_valid  out  1  FP register-file write enable
- fp_wb_addr  out  RD_W  FP write index
- fp_wb_data  out  STD+1  FP write data
- int_wb_valid  out  1  integer register-file write enable
- int_wb_addr  out  RD_W  integer write index
- int_wb_data  out  32  integer write data
- csr_valid  in  1  CSR access request
- csr_op  in  2  01 write, 10 set, 11 clear, 00 read-only
- csr_addr  in  12  0x001 fflags, 0x002 frm, 0x003 fcsr
- csr_wdata  in  32  CSR write/mask data
- csr_ready  out  1  access accepted this cycle
- csr_rdata  out  32  read data, valid when csr_valid and csr_ready
- csr_illegal  out  1  unsupported address; valid with csr_ready
- fflags  out  5  architectural fflags
- frm  out  3  architectural frm
- busy  out  1  any op in flight

Behaviour:
- Reset (async, rst_l=0): pipe valids, fflags, frm and all wb outputs clear to 0. Release is synchronous to the next clk edge. Reset mid-operation discards every in-flight op with no writeback and no flag update.
- Rounding resolution: frm_w = (issue_rm==3'b111) ? frm : issue_rm. rm_illegal = issue_valid & (frm_w ∈ {101,110,111}).
- Issue: an op with rm_illegal=1 is not entered into the tracking pipe.
- Tracking pipe: LAT-deep shift register of {valid, rd, is_fp}, advanced every cycle. No stall; the FPU is non-blocking.
- Retire:
  - An op issued at edge t retires in the cycle after edge t+LAT-1, i.e. while fpu_* carry its result.
  - At the retire edge the block registers wb outputs (valid for exactly one cycle) and ORs fpu_flags into fflags.
  - Issue-to-wb_valid latency is LAT+1 edges. Back-to-back issues give back-to-back writebacks.
  - is_fp=1: fp_wb_valid=1, data = fpu_result.
  - is_fp=0: int_wb_valid = (rd!=0), data = fpu_result_rd.
  - Retire with no valid: both wb_valid are 0 and data/addr hold their previous value.
- busy = OR of pipe valid bits.
- CSR access:
  - csr_ready = ~(busy & addr∈{0x001,0x003}). The frm address is always ready.
  - Accesses are applied only when csr_valid & csr_ready.
  - fcsr = {24'b0, frm, fflags}.
  - csr_rdata returns the pre-update value (zero-extended).
  - Update is new = wdata (write), old|wdata (set), old&~wdata (clear), truncated to field width. op 00 leaves state unchanged.
  - Any other address: csr_illegal=1, csr_rdata=0, no state change.
  - frm writes of 101..111 are stored; they cause rm_illegal only for dynamic-rm issues.
- Simultaneous events:
  - CSR frm write and a dynamic-rm issue in the same cycle: the issue uses the old frm. The new value takes effect at the next cycle.
  - A flag retire cannot coincide with an fflags/fcsr update (csr_ready gate). Frm updates and flag retires proceed in parallel.

Test Plan:
- Reset with ops in flight: issue fadd rd=3 is_fp=1, assert rst_l=0 mid-pipe -> no fp_wb_valid ever; fflags=0, frm=0.
- Dynamic rm: frm=3'b010, issue_rm=3'b111 -> frm_w=010. Set frm=3'b101 and issue dynamic -> rm_illegal=1, no writeback LAT+1 later.
- Back-to-back routing: issue FP rd=1, int rd=2, int rd=0 on consecutive cycles with results 16'h3C00, 32'h1, 32'h1 -> fp_wb(1,3C00), int_wb(2,1), no int_wb for rd=0, on consecutive cycles starting LAT+1 edges after the first issue.
- Flag accumulation: two retires with flags 5'b00001 then 5'b10000 -> fflags=5'b10001. CSR clear 0x001 mask 0x1F -> csr_rdata=0x11, then fflags=0.
- Stall: csr read of fcsr one cycle after issue -> csr_ready=0 until busy=0, then csr_rdata includes that op's flags. Frm read in the same window -> csr_ready=1.
- CSR fcsr write 32'hFFFF_FFE5 -> frm=3'b111, fflags=5'b00101, readback 32'h0000_00E5. csr_addr 0x004 -> csr_illegal=1, csr_rdata=0.
